// File: rtl/prs_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : prs_mon_pkg
// Brief  : Shared states, event codes and event record for the PRS monitor.
// Rev    : 1.0
// ============================================================================
package prs_mon_pkg;

  localparam int c_MAX_NODE_W = 5;
  localparam int c_MAX_TS_W   = 32;

  typedef enum logic [2:0] {
    UNKNOWN = 3'd0,
    DRV_HI  = 3'd1,
    DRV_LO  = 3'd2,
    HOLD_HI = 3'd3,
    HOLD_LO = 3'd4,
    INTF    = 3'd5
  } node_state_e;

  typedef enum logic [1:0] {
    EVT_NONE      = 2'b00,
    EVT_INTERFERE = 2'b01,
    EVT_DECAY     = 2'b10
  } evt_code_e;

  // Widest event layout; each monitor instance narrows node/ts to its parameters.
  typedef struct packed {
    evt_code_e                code;
    logic [c_MAX_NODE_W-1:0]  node;
    logic [c_MAX_TS_W-1:0]    ts;
  } evt_t;

  function automatic int node_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prs_mon_fifo.sv
`default_nettype none
// ============================================================================
// Module : prs_mon_fifo
// Brief  : Synchronous first-word-fall-through event FIFO.
// Rev    : 1.0
// ============================================================================
module prs_mon_fifo
  import prs_mon_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type T_DATA = evt_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  T_DATA i_data,
  input  logic  i_pop,
  output T_DATA o_data,
  output logic  o_full,
  output logic  o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  T_DATA           r_mem [DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic            w_do_pop;
  logic            w_do_push;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/prs_node_monitor.sv
`default_nettype none
// ============================================================================
// Module : prs_node_monitor
// Brief  : Reconstructs tri-state PRS node values and queues interference/decay events.
// Rev    : 1.0
// ============================================================================
module prs_node_monitor
  import prs_mon_pkg::*;
#(
  parameter int N_NODES      = 4,
  parameter int DECAY_CYCLES = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_W         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_NODES-1:0]            i_up,
  input  logic [N_NODES-1:0]            i_down,
  output logic [N_NODES-1:0]            o_node_val,
  output logic [N_NODES-1:0]            o_node_known,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [1:0]                    o_evt_code,
  output logic [node_idx_w(N_NODES)-1:0] o_evt_node,
  output logic [TS_W-1:0]               o_evt_ts,
  output logic                          o_overflow,
  output logic [7:0]                    o_drop_cnt
);

  localparam int c_NODE_W = node_idx_w(N_NODES);
  localparam int c_CNT_W  = $clog2(DECAY_CYCLES + 1);

  typedef struct packed {
    evt_code_e             code;
    logic [c_NODE_W-1:0]   node;
    logic [TS_W-1:0]       ts;
  } evt_loc_t;

  logic [N_NODES-1:0]  r_up, r_down;
  logic [TS_W-1:0]     r_ts;
  logic [N_NODES-1:0]  r_pend_intf, r_pend_decay;
  logic [TS_W-1:0]     r_ts_intf [N_NODES];
  logic [TS_W-1:0]     r_ts_decay [N_NODES];
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;

  logic [N_NODES-1:0]  w_det_intf, w_det_decay;
  logic [N_NODES-1:0]  w_clr_intf, w_clr_decay;
  logic [N_NODES-1:0]  w_drop_intf, w_drop_decay;
  logic                w_grant_any, w_grant_decay;
  logic [c_NODE_W-1:0] w_grant_node;
  logic [TS_W-1:0]     w_grant_ts;
  logic                w_full, w_empty, w_pop, w_push;
  logic [6:0]          w_drop_num;
  logic [8:0]          w_drop_sum;
  evt_loc_t            w_push_data, w_head;

  for (genvar gi = 0; gi < N_NODES; gi++) begin : g_node
    node_state_e        r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_float_cnt, w_float_nxt, w_float_inc;
    logic               w_det_i, w_det_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state     <= UNKNOWN;
        r_float_cnt <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_float_cnt <= w_float_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_float_nxt = r_float_cnt;
      w_det_i     = 1'b0;
      w_det_d     = 1'b0;
      // The first floating cycle after a drive counts as one.
      if (r_state == HOLD_HI || r_state == HOLD_LO) w_float_inc = r_float_cnt + 1'b1;
      else                                          w_float_inc = c_CNT_W'(1);
      case ({r_up[gi], r_down[gi]})
        2'b10: begin w_state_nxt = DRV_HI; w_float_nxt = '0; end
        2'b01: begin w_state_nxt = DRV_LO; w_float_nxt = '0; end
        2'b11: begin
          w_state_nxt = INTF;
          w_float_nxt = '0;
          w_det_i     = (r_state != INTF);
        end
        default: begin
          if (r_state inside {DRV_HI, HOLD_HI, DRV_LO, HOLD_LO}) begin
            if (w_float_inc >= c_CNT_W'(DECAY_CYCLES)) begin
              w_state_nxt = UNKNOWN;
              w_float_nxt = '0;
              w_det_d     = 1'b1;
            end else begin
              if (r_state == DRV_HI || r_state == HOLD_HI) w_state_nxt = HOLD_HI;
              else                                         w_state_nxt = HOLD_LO;
              w_float_nxt = w_float_inc;
            end
          end
        end
      endcase
    end

    assign w_det_intf[gi]   = w_det_i;
    assign w_det_decay[gi]  = w_det_d;
    assign o_node_val[gi]   = (r_state == DRV_HI) || (r_state == HOLD_HI);
    assign o_node_known[gi] = r_state inside {DRV_HI, HOLD_HI, DRV_LO, HOLD_LO};
    assign w_clr_intf[gi]   = w_push & ~w_grant_decay & (w_grant_node == c_NODE_W'(gi));
    assign w_clr_decay[gi]  = w_push &  w_grant_decay & (w_grant_node == c_NODE_W'(gi));
  end

  // Scanning downward lets the lowest index win, and INTERFERE win over DECAY.
  always_comb begin
    w_grant_any   = 1'b0;
    w_grant_decay = 1'b0;
    w_grant_node  = '0;
    w_grant_ts    = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (r_pend_decay[i]) begin
        w_grant_any   = 1'b1;
        w_grant_decay = 1'b1;
        w_grant_node  = c_NODE_W'(i);
        w_grant_ts    = r_ts_decay[i];
      end
      if (r_pend_intf[i]) begin
        w_grant_any   = 1'b1;
        w_grant_decay = 1'b0;
        w_grant_node  = c_NODE_W'(i);
        w_grant_ts    = r_ts_intf[i];
      end
    end
  end

  assign w_pop  = ~w_empty & i_evt_ready;
  assign w_push = w_grant_any & (~w_full | w_pop);

  assign w_push_data.code = w_grant_decay ? EVT_DECAY : EVT_INTERFERE;
  assign w_push_data.node = w_grant_node;
  assign w_push_data.ts   = w_grant_ts;

  // A re-detection only counts as lost when it cannot be merged into a queued slot.
  assign w_drop_intf  = w_det_intf  & r_pend_intf  & ~w_clr_intf  & {N_NODES{w_full}};
  assign w_drop_decay = w_det_decay & r_pend_decay & ~w_clr_decay & {N_NODES{w_full}};

  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < N_NODES; i++) begin
      w_drop_num = w_drop_num + 7'(w_drop_intf[i]) + 7'(w_drop_decay[i]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {2'b00, w_drop_num};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_up         <= '0;
      r_down       <= '0;
      r_ts         <= '0;
      r_pend_intf  <= '0;
      r_pend_decay <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        r_ts_intf[i]  <= '0;
        r_ts_decay[i] <= '0;
      end
    end else begin
      r_up         <= i_up;
      r_down       <= i_down;
      r_ts         <= r_ts + TS_W'(1);
      r_pend_intf  <= (r_pend_intf  & ~w_clr_intf)  | w_det_intf;
      r_pend_decay <= (r_pend_decay & ~w_clr_decay) | w_det_decay;
      for (int i = 0; i < N_NODES; i++) begin
        if (w_det_intf[i] && !(r_pend_intf[i] && !w_clr_intf[i]))
          r_ts_intf[i] <= r_ts;
        if (w_det_decay[i] && !(r_pend_decay[i] && !w_clr_decay[i]))
          r_ts_decay[i] <= r_ts;
      end
      if ((|w_drop_intf) || (|w_drop_decay)) r_overflow <= 1'b1;
      r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  prs_mon_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .T_DATA (evt_loc_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (i_evt_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_evt_valid = ~w_empty;
  assign o_evt_code  = w_head.code;
  assign o_evt_node  = w_head.node;
  assign o_evt_ts    = w_head.ts;
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prs_node_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_prs_node_monitor
// Brief  : Directed and random stimulus against an event-level reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_prs_node_monitor;

  localparam int N     = 4;
  localparam int DC    = 16;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] up, down;
  logic         evt_ready;

  logic [N-1:0] node_val, node_known, node_val2, node_known2;
  logic         evt_valid, evt_valid2, overflow, overflow2;
  logic [1:0]   evt_code, evt_code2, evt_node, evt_node2;
  logic [15:0]  evt_ts;
  logic [3:0]   evt_ts2;
  logic [7:0]   drop_cnt, drop_cnt2;

  always #5 clk = ~clk;

  prs_node_monitor #(.N_NODES(N), .DECAY_CYCLES(DC), .FIFO_DEPTH(DEPTH), .TS_W(16)) u_dut (
    .clk(clk), .reset(reset), .i_up(up), .i_down(down),
    .o_node_val(node_val), .o_node_known(node_known),
    .o_evt_valid(evt_valid), .i_evt_ready(evt_ready),
    .o_evt_code(evt_code), .o_evt_node(evt_node), .o_evt_ts(evt_ts),
    .o_overflow(overflow), .o_drop_cnt(drop_cnt)
  );

  prs_node_monitor #(.N_NODES(N), .DECAY_CYCLES(DC), .FIFO_DEPTH(DEPTH), .TS_W(4)) u_dut_ts4 (
    .clk(clk), .reset(reset), .i_up(up), .i_down(down),
    .o_node_val(node_val2), .o_node_known(node_known2),
    .o_evt_valid(evt_valid2), .i_evt_ready(evt_ready),
    .o_evt_code(evt_code2), .o_evt_node(evt_node2), .o_evt_ts(evt_ts2),
    .o_overflow(overflow2), .o_drop_cnt(drop_cnt2)
  );

  // Reference model: node value/known flags, float ages, pending slots, event queue.
  typedef struct { int code; int node; int ts; } mevt_t;
  mevt_t m_q[$];
  bit    m_rup[N], m_rdn[N], m_kn[N], m_val[N], m_intf[N];
  int    m_age[N];
  bit    m_pi[N], m_pd[N];
  int    m_tsi[N], m_tsd[N];
  int    m_ts;
  bit    m_ovf;
  int    m_drop;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_one();
    m_ovf = 1'b1;
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_step();
    bit pop, full, push, di, dd;
    int gn, gc;
    mevt_t e;
    if (reset) begin
      m_q.delete();
      for (int i = 0; i < N; i++) begin
        m_rup[i] = 0; m_rdn[i] = 0; m_kn[i] = 0; m_val[i] = 0; m_intf[i] = 0;
        m_age[i] = 0; m_pi[i] = 0; m_pd[i] = 0;
      end
      m_ts = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    pop  = (m_q.size() > 0) && evt_ready;
    full = (m_q.size() == DEPTH);
    gn = -1; gc = 0;
    for (int i = 0; i < N; i++) begin
      if (gn < 0 && m_pi[i]) begin gn = i; gc = 1; end
      else if (gn < 0 && m_pd[i]) begin gn = i; gc = 2; end
    end
    push = (gn >= 0) && (!full || pop);
    if (push) begin
      e.code = gc; e.node = gn; e.ts = (gc == 1) ? m_tsi[gn] : m_tsd[gn];
      if (gc == 1) m_pi[gn] = 0; else m_pd[gn] = 0;
    end
    for (int i = 0; i < N; i++) begin
      di = 0; dd = 0;
      if (m_rup[i] && m_rdn[i]) begin
        di = !m_intf[i];
        m_intf[i] = 1; m_kn[i] = 0; m_val[i] = 0; m_age[i] = 0;
      end else if (m_rup[i] || m_rdn[i]) begin
        m_intf[i] = 0; m_kn[i] = 1; m_val[i] = m_rup[i]; m_age[i] = 0;
      end else if (m_kn[i]) begin
        m_age[i]++;
        if (m_age[i] >= DC) begin m_kn[i] = 0; m_val[i] = 0; m_age[i] = 0; dd = 1; end
      end
      if (di) begin
        if (m_pi[i]) begin if (full) drop_one(); end
        else begin m_pi[i] = 1; m_tsi[i] = m_ts; end
      end
      if (dd) begin
        if (m_pd[i]) begin if (full) drop_one(); end
        else begin m_pd[i] = 1; m_tsd[i] = m_ts; end
      end
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(e);
    for (int i = 0; i < N; i++) begin m_rup[i] = up[i]; m_rdn[i] = down[i]; end
    m_ts = (m_ts + 1) & 16'hFFFF;
  endtask

  task automatic check_outputs();
    logic [N-1:0] ev, ek;
    for (int i = 0; i < N; i++) begin ev[i] = m_val[i]; ek[i] = m_kn[i]; end
    chk("node_val",    32'(node_val),    32'(ev));
    chk("node_known",  32'(node_known),  32'(ek));
    chk("evt_valid",   32'(evt_valid),   32'(m_q.size() > 0));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
    chk("ts4_node_val", 32'(node_val2),  32'(ev));
    chk("ts4_known",   32'(node_known2), 32'(ek));
    chk("ts4_valid",   32'(evt_valid2),  32'(m_q.size() > 0));
    chk("ts4_overflow", 32'(overflow2),  32'(m_ovf));
    chk("ts4_drop_cnt", 32'(drop_cnt2),  32'(m_drop));
    if (m_q.size() > 0) begin
      chk("evt_code",  32'(evt_code),  32'(m_q[0].code));
      chk("evt_node",  32'(evt_node),  32'(m_q[0].node));
      chk("evt_ts",    32'(evt_ts),    32'(m_q[0].ts));
      chk("ts4_code",  32'(evt_code2), 32'(m_q[0].code));
      chk("ts4_node",  32'(evt_node2), 32'(m_q[0].node));
      chk("ts4_ts",    32'(evt_ts2),   32'(m_q[0].ts % 16));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int t3;
    logic [N-1:0] pu, pd;

    reset = 1'b1; up = '0; down = '0; evt_ready = 1'b0;
    ticks(2);
    chk("rst_known", 32'(node_known), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_drop",  32'(drop_cnt), 32'h0);

    // 1: drive node0 high straight out of reset
    reset = 1'b0; up = 4'b0001;
    ticks(2);
    chk("t1_val0",   32'(node_val[0]), 32'h1);
    chk("t1_known0", 32'(node_known[0]), 32'h1);
    chk("t1_noevt",  32'(evt_valid), 32'h0);

    // 2: a 15-cycle float is harmless, a 16-cycle float decays
    up = '0; ticks(15);
    up = 4'b0001; ticks(2);
    chk("t2_nodecay15", 32'(evt_valid), 32'h0);
    chk("t2_known15",   32'(node_known[0]), 32'h1);
    up = '0; ticks(18);
    chk("t2_valid",  32'(evt_valid), 32'h1);
    chk("t2_code",   32'(evt_code), 32'h2);
    chk("t2_node",   32'(evt_node), 32'h0);
    chk("t2_known0", 32'(node_known[0]), 32'h0);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // 3: simultaneous interference on nodes 2 and 1
    t3 = m_ts;
    up = 4'b0110; down = 4'b0110; tick();
    up = '0; down = '0; ticks(4);
    chk("t3_node_a", 32'(evt_node), 32'h1);
    chk("t3_code_a", 32'(evt_code), 32'h1);
    chk("t3_ts_a",   32'(evt_ts), 32'((t3 + 1) & 16'hFFFF));
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("t3_node_b", 32'(evt_node), 32'h2);
    chk("t3_ts_b",   32'(evt_ts), 32'((t3 + 1) & 16'hFFFF));
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("t3_empty",  32'(evt_valid), 32'h0);

    // 4: fill the FIFO from node3, leave one pending, then re-trigger it
    for (int k = 0; k < 9; k++) begin
      up = 4'b1000; down = 4'b1000; tick();
      up = 4'b1000; down = 4'b0000; tick();
    end
    up = 4'b1000; down = 4'b1000; tick();
    up = 4'b1000; down = 4'b0000; ticks(3);
    chk("t4_overflow", 32'(overflow), 32'h1);
    chk("t4_drop",     32'(drop_cnt), 32'h1);
    evt_ready = 1'b1; ticks(8); evt_ready = 1'b0;
    chk("t4_tail_valid", 32'(evt_valid), 32'h1);
    chk("t4_tail_node",  32'(evt_node), 32'h3);
    chk("t4_tail_code",  32'(evt_code), 32'h1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("t4_drained", 32'(evt_valid), 32'h0);

    // 5: reset with three queued events
    up = 4'b0111; down = '0; tick();
    up = 4'b0111; down = 4'b0111; tick();
    up = '0; down = '0; ticks(5);
    chk("t5_queued", 32'(evt_valid), 32'h1);
    reset = 1'b1; tick();
    chk("t5_valid", 32'(evt_valid), 32'h0);
    chk("t5_drop",  32'(drop_cnt), 32'h0);
    chk("t5_ovf",   32'(overflow), 32'h0);

    // 6: detection 17 cycles after reset, narrow timestamp wraps
    reset = 1'b0; ticks(16);
    up = 4'b0001; down = 4'b0001; tick();
    up = '0; down = '0; ticks(2);
    chk("t6_valid", 32'(evt_valid), 32'h1);
    chk("t6_ts16",  32'(evt_ts), 32'd17);
    chk("t6_ts4",   32'(evt_ts2), 32'd1);
    evt_ready = 1'b1; tick();

    // Random phase: slowly changing guards, variable back-pressure, one mid-run reset
    pu = '0; pd = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) begin
          case ($urandom_range(5))
            3:       begin pu[i] = 1'b1; pd[i] = 1'b0; end
            4:       begin pu[i] = 1'b0; pd[i] = 1'b1; end
            5:       begin pu[i] = 1'b1; pd[i] = 1'b1; end
            default: begin pu[i] = 1'b0; pd[i] = 1'b0; end
          endcase
        end
      end
      up = pu; down = pd;
      evt_ready = (c < 300) ? ($urandom_range(5) == 0) : ($urandom_range(3) != 0);
      reset = (c == 450);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
